// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the PISO serializer: state encoding and counter sizing.
// PAR exists only when the PARITY_EN macro is defined.
package piso_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;

`ifdef PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        PAR   = ST_PAR
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT
    } state_e;
`endif

    // Bits needed to hold W-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel input handshake and serial output bundle of the PISO serializer.
interface piso_serializer_if #(
    parameter int W = 8
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         sout;
    logic         sout_valid;
    logic         sout_last;
    logic         busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, sout, sout_valid, sout_last, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, sout, sout_valid, sout_last, busy
    );
endinterface

// File: rtl/piso_serializer_shift_reg.sv
// Loadable W-bit shift register; the serial tap is the end bit chosen by MSB_FIRST.
module shift_reg_core #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] d_i,
    output logic         ser_o
);

    logic [W-1:0] data_q, data_d;

    // A load wins over a shift so a new word can enter on the last-bit cycle.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = d_i;
        end else if (shift_i) begin
            data_d = MSB_FIRST ? {data_q[W-2:0], 1'b0} : {1'b0, data_q[W-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign ser_o = MSB_FIRST ? data_q[W-1] : data_q[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with gapless back-to-back frames.
// Defining PARITY_EN appends an even-parity bit to every frame.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    piso_serializer_if.slave io
);

    localparam int            CW       = cnt_width(W);
    localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;
    logic          last_bit;
    logic          shift_en;
    logic          ser_bit;
    logic          sout_w;
    logic          valid_w;
    logic          busy_w;

`ifdef PARITY_EN
    logic par_q, par_d;
    assign last_bit = (state_q == PAR);
`else
    assign last_bit = (state_q == SHIFT) && (cnt_q == '0);
`endif

    assign io.in_ready   = (state_q == IDLE) | last_bit;
    assign accept        = io.in_valid & io.in_ready;
    assign io.sout       = sout_w;
    assign io.sout_valid = valid_w;
    assign io.sout_last  = last_bit;
    assign io.busy       = busy_w;

    shift_reg_core #(
        .W         (W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .shift_i (shift_en),
        .d_i     (io.in_data),
        .ser_o   (ser_bit)
    );

    // Accept is only possible in IDLE or on the last bit, so it always restarts a frame.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_en = 1'b0;
        sout_w   = 1'b0;
        valid_w  = 1'b0;
        busy_w   = 1'b0;
`ifdef PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            IDLE: ;
            SHIFT: begin
                sout_w   = ser_bit;
                valid_w  = 1'b1;
                busy_w   = 1'b1;
                shift_en = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
`ifdef PARITY_EN
                    state_d = PAR;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef PARITY_EN
            PAR: begin
                sout_w  = par_q;
                valid_w = 1'b1;
                busy_w  = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = SHIFT;
            cnt_d   = CNT_LOAD;
`ifdef PARITY_EN
            par_d   = ^io.in_data;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances driven in lockstep.
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    // Input word, expected serial streams written first-bit-leftmost, and parity.
    typedef struct {
        logic [7:0] word;
        logic [7:0] expMsb;
        logic [7:0] expLsb;
        logic       expPar;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   testsRun    = 0;
    int   testsFailed = 0;
    vec_t vecs[7];

    always #5 clk = ~clk;

    piso_serializer_if #(.W(W)) ifM ();
    piso_serializer_if #(.W(W)) ifL ();

    piso_serializer #(.W(W), .MSB_FIRST(1'b1)) dutM (
        .clk (clk),
        .rst (rst),
        .io  (ifM)
    );

    piso_serializer #(.W(W), .MSB_FIRST(1'b0)) dutL (
        .clk (clk),
        .rst (rst),
        .io  (ifL)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic driveIn(input logic v, input logic [7:0] d);
        ifM.in_valid = v;
        ifM.in_data  = d;
        ifL.in_valid = v;
        ifL.in_data  = d;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " msb sout"},       32'(ifM.sout),       32'd0);
        checkOutput({tag, " msb sout_valid"}, 32'(ifM.sout_valid), 32'd0);
        checkOutput({tag, " msb sout_last"},  32'(ifM.sout_last),  32'd0);
        checkOutput({tag, " msb busy"},       32'(ifM.busy),       32'd0);
        checkOutput({tag, " msb in_ready"},   32'(ifM.in_ready),   32'd1);
        checkOutput({tag, " lsb sout"},       32'(ifL.sout),       32'd0);
        checkOutput({tag, " lsb sout_valid"}, 32'(ifL.sout_valid), 32'd0);
        checkOutput({tag, " lsb sout_last"},  32'(ifL.sout_last),  32'd0);
        checkOutput({tag, " lsb busy"},       32'(ifL.busy),       32'd0);
        checkOutput({tag, " lsb in_ready"},   32'(ifL.in_ready),   32'd1);
    endtask

    // Bit i of a frame: data bits come from the hand-written streams, the extra bit is parity.
    task automatic checkBit(input string tag, input int i, input vec_t v);
        logic expM, expL, expLast;
        expM    = (i < W) ? v.expMsb[W-1-i] : v.expPar;
        expL    = (i < W) ? v.expLsb[W-1-i] : v.expPar;
        expLast = (i == FL - 1);
        checkOutput({tag, " msb sout"},       32'(ifM.sout),       32'(expM));
        checkOutput({tag, " lsb sout"},       32'(ifL.sout),       32'(expL));
        checkOutput({tag, " msb sout_valid"}, 32'(ifM.sout_valid), 32'd1);
        checkOutput({tag, " lsb sout_valid"}, 32'(ifL.sout_valid), 32'd1);
        checkOutput({tag, " msb sout_last"},  32'(ifM.sout_last),  32'(expLast));
        checkOutput({tag, " lsb sout_last"},  32'(ifL.sout_last),  32'(expLast));
        checkOutput({tag, " msb busy"},       32'(ifM.busy),       32'd1);
        checkOutput({tag, " msb in_ready"},   32'(ifM.in_ready),   32'(expLast));
    endtask

    // One frame from IDLE; with jam set, in_valid stays high with new data until the last bit.
    task automatic applyStimulus(input vec_t v, input bit jam);
        @(negedge clk);
        driveIn(1'b1, v.word);
        @(posedge clk);
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            checkBit(jam ? "jam frame" : "frame", i, v);
            if (jam && i < FL - 1) begin
                driveIn(1'b1, 8'($urandom_range(0, 255)));
            end else begin
                driveIn(1'b0, 8'h00);
            end
        end
        @(negedge clk);
        checkIdle("after frame");
    endtask

    task automatic backToBack(input vec_t a, input vec_t b);
        @(negedge clk);
        driveIn(1'b1, a.word);
        @(posedge clk);
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            checkBit("b2b first", i, a);
            if (i == FL - 1) begin
                driveIn(1'b1, b.word);
            end else begin
                driveIn(1'b0, 8'h00);
            end
        end
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            checkBit("b2b second", i, b);
            driveIn(1'b0, 8'h00);
        end
        @(negedge clk);
        checkIdle("after b2b");
    endtask

    task automatic resetMidFrame(input vec_t v);
        @(negedge clk);
        driveIn(1'b1, v.word);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkBit("pre reset", i, v);
            driveIn(1'b0, 8'h00);
        end
        #1 rst = 1'b1;
        #1 checkIdle("async reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkIdle("post reset");
        end
    endtask

    initial begin
        rst = 1'b1;
        driveIn(1'b0, 8'h00);

        vecs[0] = '{8'hA5, 8'hA5, 8'hA5, 1'b0};
        vecs[1] = '{8'h01, 8'h01, 8'h80, 1'b1};
        vecs[2] = '{8'h3C, 8'h3C, 8'h3C, 1'b0};
        vecs[3] = '{8'h0F, 8'h0F, 8'hF0, 1'b0};
        vecs[4] = '{8'hC8, 8'hC8, 8'h13, 1'b1};
        vecs[5] = '{8'h07, 8'h07, 8'hE0, 1'b1};
        vecs[6] = '{8'h03, 8'h03, 8'hC0, 1'b0};

        repeat (2) @(negedge clk);
        checkIdle("reset");
        rst = 1'b0;
        @(negedge clk);
        checkIdle("idle");

        for (int k = 0; k < 7; k++) begin
            applyStimulus(vecs[k], 1'b0);
        end

        backToBack(vecs[0], vecs[2]);
        applyStimulus(vecs[3], 1'b1);
        resetMidFrame(vecs[0]);
        applyStimulus(vecs[4], 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
